// File: rtl/median5_stream_sched.sv
// Streaming 5-tap sliding-window median filter built around one time-shared comparator.
// Optional MEDIAN_EARLY_EXIT_EN: end the compare phase at the first candidate that qualifies.
module median5_stream_sched #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          ngreset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic [2:0]    fill_cnt
);

`ifdef MEDIAN_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StCmp, StOut} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] win_q [5];
    logic [DW-1:0] win_d [5];
    logic [2:0]    fill_q, fill_d;
    logic [2:0]    cand_q, cand_d;
    logic [2:0]    step_q, step_d;
    logic [2:0]    wins_q, wins_d;
    logic [2:0]    med_idx_q, med_idx_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic          accept;
    logic          beat;
    logic          last_step;
    logic          qualifies;
    logic [2:0]    opp;
    logic [2:0]    wins_sum;
    logic [2:0]    final_idx;
    logic [DW-1:0] cand_val;
    logic [DW-1:0] opp_val;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign fill_cnt  = fill_q;
    assign out_data  = out_data_q;

    assign accept = in_valid && in_ready && !flush;

    // Opponent skips the candidate itself: steps 0..3 map onto the four other taps.
    assign opp      = (step_q < cand_q) ? step_q : step_q + 3'd1;
    assign cand_val = win_q[cand_q];
    assign opp_val  = win_q[opp];

    // Equal values are ordered by index so every tap gets a unique rank.
    assign beat      = (cand_val > opp_val) || ((cand_val == opp_val) && (cand_q > opp));
    assign wins_sum  = wins_q + {2'b00, beat};
    assign last_step = (step_q == 3'd3);
    assign qualifies = last_step && (wins_sum == 3'd2);
    assign final_idx = qualifies ? cand_q : med_idx_q;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        fill_d     = fill_q;
        cand_d     = cand_q;
        step_d     = step_q;
        wins_d     = wins_q;
        med_idx_d  = med_idx_q;
        out_data_d = out_data_q;

        if (flush) begin
            state_d = StIdle;
            fill_d  = 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        win_d[4] = win_q[3];
                        win_d[3] = win_q[2];
                        win_d[2] = win_q[1];
                        win_d[1] = win_q[0];
                        win_d[0] = in_data;
                        fill_d   = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
                        if (fill_d == 3'd5) begin
                            state_d = StCmp;
                            cand_d  = 3'd0;
                            step_d  = 3'd0;
                            wins_d  = 3'd0;
                        end
                    end
                end
                StCmp: begin
                    if (qualifies) begin
                        med_idx_d = cand_q;
                    end
                    if (last_step) begin
                        cand_d = cand_q + 3'd1;
                        step_d = 3'd0;
                        wins_d = 3'd0;
                        if ((EarlyExit && qualifies) || (cand_q == 3'd4)) begin
                            state_d    = StOut;
                            out_data_d = win_q[final_idx];
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                        wins_d = wins_sum;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge ngreset) begin
        if (!ngreset) begin
            state_q    <= StIdle;
            for (int i = 0; i < 5; i++) begin
                win_q[i] <= '0;
            end
            fill_q     <= 3'd0;
            cand_q     <= 3'd0;
            step_q     <= 3'd0;
            wins_q     <= 3'd0;
            med_idx_q  <= 3'd0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            fill_q     <= fill_d;
            cand_q     <= cand_d;
            step_q     <= step_d;
            wins_q     <= wins_d;
            med_idx_q  <= med_idx_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_median5_stream_sched.sv
// Self-checking bench for median5_stream_sched: directed scenarios plus random samples
// compared against a sort-based median model.
module tb_median5_stream_sched;

    localparam int DW = 8;

`ifdef MEDIAN_EARLY_EXIT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          ngreset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [2:0]    fill_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model window: mw[0] is the newest sample.
    logic [7:0] mw [5];
    int         mfill = 0;

    median5_stream_sched #(.DW(DW)) dut (
        .clk      (clk),
        .ngreset  (ngreset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .fill_cnt (fill_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Median = middle of the five (value, index) keys in ascending order.
    task automatic model_median(output logic [7:0] val, output int idx);
        logic [10:0] k [5];
        logic [10:0] t;
        for (int i = 0; i < 5; i++) k[i] = {mw[i], 3'(i)};
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4 - a; b++) begin
                if (k[b] > k[b+1]) begin
                    t = k[b]; k[b] = k[b+1]; k[b+1] = t;
                end
            end
        end
        val = k[2][10:3];
        idx = int'(k[2][2:0]);
    endtask

    task automatic model_reset_window();
        for (int i = 0; i < 5; i++) mw[i] = 8'd0;
        mfill = 0;
    endtask

    task automatic push(input logic [7:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard <= 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 100) check("push_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 4; i > 0; i--) mw[i] = mw[i-1];
        mw[0] = d;
        if (mfill < 5) mfill++;
    endtask

    // Called #1 after the accept edge; returns with out_valid high (or after timeout).
    task automatic await_result(input string tag);
        logic [7:0] ev;
        int         eidx;
        int         lat;
        int         cnt;
        model_median(ev, eidx);
        lat = Early ? 4 * (eidx + 1) : 20;
        cnt = 0;
        while (!out_valid && cnt <= 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(lat));
        check({tag, "_median"}, 32'(out_data), 32'(ev));
    endtask

    task automatic feed(input logic [7:0] d, input string tag);
        push(d);
        check({tag, "_fill"}, 32'(fill_cnt), 32'(mfill));
        if (mfill < 5) begin
            check({tag, "_no_out"}, {30'd0, out_valid, busy}, 32'd0);
        end else begin
            await_result(tag);
            @(posedge clk);
            #1;
            check({tag, "_handshake"}, {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] hold;
        logic       seen;
        model_reset_window();

        // Reset state
        #12;
        check("rst_outputs", {out_data, 1'b0, out_valid, busy, fill_cnt}, 32'd0);
        @(negedge clk);
        ngreset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic sliding sequence
        feed(8'd10, "s1a");
        feed(8'd50, "s1b");
        feed(8'd30, "s1c");
        feed(8'd20, "s1d");
        feed(8'd40, "s1e");
        feed(8'd60, "s1f");
        feed(8'd5,  "s1g");

        // Ties (window keeps sliding, so every accept yields a result)
        for (int i = 0; i < 5; i++) feed(8'd7, "tie7");
        feed(8'd9, "tie9"); feed(8'd1, "tie9"); feed(8'd9, "tie9");
        feed(8'd1, "tie9"); feed(8'd9, "tie9");
        feed(8'd3, "tie3"); feed(8'd3, "tie3"); feed(8'd8, "tie3");
        feed(8'd8, "tie3"); feed(8'd0, "tie3");

        // Backpressure with a held input sample
        out_ready = 1'b0;
        push(8'd200);
        await_result("bp");
        hold = out_data;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd100;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {22'd0, out_valid, in_ready, out_data}, {22'd0, 1'b1, 1'b0, hold});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {29'd0, out_valid, busy, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept", 32'(busy), 32'd1);
        for (int i = 4; i > 0; i--) mw[i] = mw[i-1];
        mw[0] = 8'd100;
        await_result("bp2");
        @(posedge clk);
        #1;

        // Flush while idle with in_valid: sample must not be taken
        model_reset_window();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        feed(8'd11, "fl_idle");
        feed(8'd12, "fl_idle");
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_idle_fill", 32'(fill_cnt), 32'd0);
        model_reset_window();

        // Flush during compare
        for (int i = 0; i < 4; i++) feed(8'(40 + i * 7), "fl_pre");
        push(8'd77);
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_cmp_state", {28'd0, out_valid, fill_cnt}, 32'd0);
        model_reset_window();
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("fl_cmp_no_out", 32'(seen), 32'd0);
        for (int i = 0; i < 5; i++) feed(8'($urandom_range(0, 255)), "fl_post");

        // Asynchronous reset mid-compare
        push(8'd250);
        repeat (2) @(posedge clk);
        #3;
        ngreset = 1'b0;
        #1;
        check("arst_outputs", {out_data, 1'b0, out_valid, busy, fill_cnt}, 32'd0);
        @(negedge clk);
        ngreset = 1'b1;
        model_reset_window();
        feed(8'd10, "rec"); feed(8'd50, "rec"); feed(8'd30, "rec");
        feed(8'd20, "rec"); feed(8'd40, "rec");

        // Random stream, biased toward small values to exercise ties
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) feed(8'($urandom_range(0, 3)), "rnd");
            else feed(8'($urandom_range(0, 255)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
